// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels and the
// default target address used by both this target and the write controllers.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    MACK      = 4'd8,
    IGNORE    = 4'd9
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] I2C_DEV_ADDR = 7'h40;

  // True when the address byte (7-bit address + R/W) selects this target.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte[7:1] == dev;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus level filter for one I2C line. The filtered
// level only follows the input after FILT_LEN consecutive differing samples;
// rise/fall strobe in the same cycle the filtered level changes.
`timescale 1ns/1ps
module i2c_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] CNT_LOAD = 4'(FILT_LEN - 1);

  logic       sync0;
  logic       sync1;
  logic [3:0] cnt;

  // Bring the raw pin into the clk domain; idle bus level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= line_in;
      sync1 <= sync0;
    end
  end

  // Down-count while the synchronised level disagrees; accept it at terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b1;
      cnt   <= CNT_LOAD;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync1 == level) begin
        cnt <= CNT_LOAD;
      end else if (cnt == 4'd0) begin
        level <= sync1;
        cnt   <= CNT_LOAD;
        rise  <= sync1;
        fall  <= ~sync1;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with an 8-bit register pointer, oversampled on clk.
// Writes: address, pointer byte, then data bytes strobed out on reg_wr_en.
// Reads: bytes fetched via reg_rd_en/reg_rdata and shifted out MSB first.
//
//  state     | meaning
//  IDLE      | bus free, waiting for START
//  ADDR      | shifting in address + R/W byte
//  ADDR_ACK  | ACKing our address; read fetch issued on ACK clock rise
//  REG       | shifting in register pointer byte
//  REG_ACK   | ACKing pointer byte
//  WDATA     | shifting in a write data byte
//  WDATA_ACK | ACKing data byte; write strobe on ACK clock rise
//  RDATA     | driving a read byte onto SDA
//  MACK      | sampling controller ACK/NACK after a read byte
//  IGNORE    | not addressed (or read ended); wait for START/STOP
`timescale 1ns/1ps
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR,
  parameter int         FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_t state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic [7:0] wdata_nxt;
  logic       wr_en_nxt, rd_en_nxt;
  logic       rd_load, rd_load_nxt;
  logic       sda_oe_nxt, busy_nxt;
  logic       rw, rw_nxt;
  logic [7:0] shift_in;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk     (clk),
    .reset   (reset),
    .line_in (scl_in),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk     (clk),
    .reset   (reset),
    .line_in (sda_in),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  // An SDA edge counts as START/STOP only if SCL is high and did not move in the same clk.
  assign start_det = sda_fall & scl_lvl & ~(scl_rise | scl_fall);
  assign stop_det  = sda_rise & scl_lvl & ~(scl_rise | scl_fall);

  assign shift_in = {shift[6:0], sda_lvl};
  assign reg_addr = ptr;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      ptr       <= 8'h00;
      reg_wdata <= 8'h00;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      rd_load   <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rw        <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      ptr       <= ptr_nxt;
      reg_wdata <= wdata_nxt;
      reg_wr_en <= wr_en_nxt;
      reg_rd_en <= rd_en_nxt;
      rd_load   <= rd_load_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      rw        <= rw_nxt;
    end
  end

  // Next-state and output decode; bus events pre-empt the per-state behaviour.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    ptr_nxt     = ptr;
    wdata_nxt   = reg_wdata;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    rd_load_nxt = reg_rd_en;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    rw_nxt      = rw;

    // Pointer advances the clk after the write strobe so reg_addr is stable with it.
    if (reg_wr_en) ptr_nxt = ptr + 8'd1;
    // Read data is valid one clk after the request.
    if (rd_load) shift_nxt = reg_rdata;

    if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE, IGNORE: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shift_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rw_nxt = sda_lvl;
              if (addr_match(shift_in, DEV_ADDR)) begin
                state_nxt = ADDR_ACK;
                busy_nxt  = 1'b1;
              end else begin
                state_nxt = IGNORE;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_rise && sda_oe && rw) rd_en_nxt = 1'b1;
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = ~ACK;
            end else begin
              bit_cnt_nxt = 4'd0;
              if (rw) begin
                state_nxt  = RDATA;
                sda_oe_nxt = ~shift[7];
              end else begin
                state_nxt  = REG;
                sda_oe_nxt = 1'b0;
              end
            end
          end
        end

        REG: begin
          if (scl_rise) begin
            shift_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr_nxt   = shift_in;
              state_nxt = REG_ACK;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shift_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state_nxt = WDATA_ACK;
          end
        end

        REG_ACK, WDATA_ACK: begin
          if (state == WDATA_ACK && scl_rise && sda_oe) begin
            wr_en_nxt = 1'b1;
            wdata_nxt = shift;
          end
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = ~ACK;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
              state_nxt   = WDATA;
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            shift_nxt   = {shift[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt = 1'b0;
              ptr_nxt    = ptr + 8'd1;
              state_nxt  = MACK;
            end else begin
              sda_oe_nxt = ~shift[7];
            end
          end
        end

        MACK: begin
          if (scl_rise) begin
            if (sda_lvl == ACK) begin
              rd_en_nxt   = 1'b1;
              bit_cnt_nxt = 4'd0;
              state_nxt   = RDATA;
            end else begin
              state_nxt = IGNORE;
            end
          end
        end

        default: begin
          state_nxt  = IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged I2C controller, register-file
// model, write-strobe log and hand-computed expected values.
`timescale 1ns/1ps
module tb_i2c_reg_target;

  localparam int Q = 25;  // clk cycles per quarter SCL period

  logic       clk;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       busy;

  logic [7:0] mem [256];
  logic [7:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  int         wr_cnt;
  int         oe_cyc;
  int         busy_cyc;

  int n_checks;
  int n_pass;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_reg_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Register-file model: read data registered one clk after the request.
  always @(posedge clk) begin
    if (reg_wr_en) mem[reg_addr] <= reg_wdata;
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
  end

  // Strobe log and activity counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_addr_log[wr_cnt] = reg_addr;
      wr_data_log[wr_cnt] = reg_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (sda_oe) oe_cyc = oe_cyc + 1;
    if (busy) busy_cyc = busy_cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(2 * Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    if (glitch) begin
      scl_m = 1'b0; wait_clks(2);
      scl_m = 1'b1; wait_clks(Q - 2);
    end else begin
      wait_clks(Q);
    end
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] data, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(data[i], glitch_bit == i);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    ack = sda_bus;
    wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic read_byte(output logic [7:0] data, input logic mack);
    data = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_clks(Q);
      scl_m = 1'b1; wait_clks(Q);
      data = {data[6:0], sda_bus};
      wait_clks(Q);
      scl_m = 1'b0;
    end
    wait_clks(Q);
    send_bit(mack, 1'b0);
  endtask

  logic       ack;
  logic [7:0] rd;
  int         wr_base;
  int         oe_base;
  int         busy_base;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    wr_cnt   = 0;
    oe_cyc   = 0;
    busy_cyc = 0;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    reset    = 1'b0;
    wait_clks(5);

    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_reg_addr", reg_addr, 8'h00);
    check_eq("rst_reg_wdata", reg_wdata, 8'h00);
    check_eq("rst_wr_en", reg_wr_en, 0);
    check_eq("rst_rd_en", reg_rd_en, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    wait_clks(20);

    // 1: single write to 0x1D
    wr_base = wr_cnt;
    i2c_start();
    write_byte(8'h80, -1, ack); check_eq("t1_ack_addr", ack, 0);
    write_byte(8'h1D, -1, ack); check_eq("t1_ack_reg", ack, 0);
    write_byte(8'h00, -1, ack); check_eq("t1_ack_data", ack, 0);
    check_eq("t1_busy_mid", busy, 1);
    i2c_stop();
    check_eq("t1_wr_count", wr_cnt - wr_base, 1);
    check_eq("t1_wr_addr", wr_addr_log[wr_base], 8'h1D);
    check_eq("t1_wr_data", wr_data_log[wr_base], 8'h00);
    check_eq("t1_busy_end", busy, 0);

    // 2: pointer wrap 0xFF -> 0x00
    wr_base = wr_cnt;
    i2c_start();
    write_byte(8'h80, -1, ack); check_eq("t2_ack_addr", ack, 0);
    write_byte(8'hFF, -1, ack); check_eq("t2_ack_reg", ack, 0);
    write_byte(8'hAA, -1, ack); check_eq("t2_ack_d0", ack, 0);
    write_byte(8'hBB, -1, ack); check_eq("t2_ack_d1", ack, 0);
    i2c_stop();
    check_eq("t2_wr_count", wr_cnt - wr_base, 2);
    check_eq("t2_wr0_addr", wr_addr_log[wr_base], 8'hFF);
    check_eq("t2_wr0_data", wr_data_log[wr_base], 8'hAA);
    check_eq("t2_wr1_addr", wr_addr_log[wr_base + 1], 8'h00);
    check_eq("t2_wr1_data", wr_data_log[wr_base + 1], 8'hBB);

    // 3: other address is ignored
    wr_base = wr_cnt; oe_base = oe_cyc; busy_base = busy_cyc;
    i2c_start();
    write_byte(8'h82, -1, ack); check_eq("t3_nack_addr", ack, 1);
    write_byte(8'h05, -1, ack);
    write_byte(8'h66, -1, ack);
    i2c_stop();
    check_eq("t3_oe_cycles", oe_cyc - oe_base, 0);
    check_eq("t3_wr_count", wr_cnt - wr_base, 0);
    check_eq("t3_busy_cycles", busy_cyc - busy_base, 0);

    // 4: preload 0x03..0x05, then pointer write + repeated START + read
    wr_base = wr_cnt;
    i2c_start();
    write_byte(8'h80, -1, ack);
    write_byte(8'h03, -1, ack);
    write_byte(8'h82, -1, ack);
    write_byte(8'h5A, -1, ack);
    write_byte(8'h3C, -1, ack); check_eq("t4_ack_preload", ack, 0);
    i2c_stop();
    check_eq("t4_preload_count", wr_cnt - wr_base, 3);
    i2c_start();
    write_byte(8'h80, -1, ack);
    write_byte(8'h03, -1, ack); check_eq("t4_ack_reg", ack, 0);
    i2c_start();
    write_byte(8'h81, -1, ack); check_eq("t4_ack_raddr", ack, 0);
    read_byte(rd, 1'b0); check_eq("t4_rd0", rd, 8'h82);
    read_byte(rd, 1'b1); check_eq("t4_rd1", rd, 8'h5A);
    check_eq("t4_released", sda_oe, 0);
    check_eq("t4_busy_after_nack", busy, 1);
    i2c_stop();
    check_eq("t4_busy_end", busy, 0);
    // pointer persists across STOP: next read continues at 0x05
    i2c_start();
    write_byte(8'h81, -1, ack);
    read_byte(rd, 1'b1); check_eq("t4_rd_persist", rd, 8'h3C);
    i2c_stop();

    // 5: async reset during bit 4 of a data byte
    wr_base = wr_cnt;
    i2c_start();
    write_byte(8'h80, -1, ack);
    write_byte(8'h10, -1, ack);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q / 2);
    #3;
    reset = 1'b0;
    #1;
    check_eq("t5_oe_in_reset", sda_oe, 0);
    check_eq("t5_busy_in_reset", busy, 0);
    check_eq("t5_ptr_in_reset", reg_addr, 8'h00);
    wait_clks(10);
    sda_m = 1'b1; scl_m = 1'b1;
    wait_clks(10);
    reset = 1'b1;
    wait_clks(20);
    check_eq("t5_no_strobe", wr_cnt - wr_base, 0);
    i2c_start();
    write_byte(8'h80, -1, ack); check_eq("t5_ack_addr", ack, 0);
    write_byte(8'h20, -1, ack);
    write_byte(8'h77, -1, ack); check_eq("t5_ack_data", ack, 0);
    i2c_stop();
    check_eq("t5_wr_count", wr_cnt - wr_base, 1);
    check_eq("t5_wr_addr", wr_addr_log[wr_base], 8'h20);
    check_eq("t5_wr_data", wr_data_log[wr_base], 8'h77);

    // 6: 2-clk SCL low glitch inside a data bit is filtered out
    wr_base = wr_cnt;
    i2c_start();
    write_byte(8'h80, -1, ack);
    write_byte(8'h30, -1, ack);
    write_byte(8'hC5, 3, ack); check_eq("t6_ack_data", ack, 0);
    i2c_stop();
    check_eq("t6_wr_count", wr_cnt - wr_base, 1);
    check_eq("t6_wr_addr", wr_addr_log[wr_base], 8'h30);
    check_eq("t6_wr_data", wr_data_log[wr_base], 8'hC5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
